quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 106 ++++++++++
 tb/tb_quad_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises A/B phases, decodes Gray-code transitions
// into step pulses, direction and a wrapping position count, and flags illegal jumps.
module quad_decoder #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic             step,
  output logic             count_up,
  output logic [NBITS-1:0] pos,
  output logic             err
);

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    FILL2 = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [NBITS-1:0] POS_ONE = NBITS'(1);

  state_t           state_q, state_d;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       prev_q, prev_d;
  logic             step_q, step_d;
  logic             count_up_q, count_up_d;
  logic [NBITS-1:0] pos_q, pos_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL0;
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      step_q     <= 1'b0;
      count_up_q <= 1'b1;
      pos_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      count_up_q <= count_up_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    s1_d       = {a_in, b_in};
    s2_d       = s1_q;
    prev_d     = s2_q;
    state_d    = state_q;
    step_d     = 1'b0;
    count_up_d = count_up_q;
    pos_d      = pos_q;
    err_d      = err_q;

    // Three fill edges let s1, s2 and prev all hold post-reset samples first.
    case (state_q)
      FILL0:   state_d = FILL1;
      FILL1:   state_d = FILL2;
      FILL2:   state_d = RUN;
      default: state_d = RUN;
    endcase

    if (state_q == RUN) begin
      case ({prev_q, s2_q})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
          step_d     = 1'b1;
          count_up_d = 1'b1;
          pos_d      = pos_q + POS_ONE;
        end
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
          step_d     = 1'b1;
          count_up_d = 1'b0;
          pos_d      = pos_q - POS_ONE;
        end
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
          err_d = 1'b1;
        end
        default: ;
      endcase
    end

    // Clear overrides pos/err only; step and direction still follow the decode.
    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  assign step     = step_q;
  assign count_up = count_up_q;
  assign pos      = pos_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: stimulus pushes expected step events,
// a negedge monitor pops and compares each step pulse the DUT emits.
module tb_quad_decoder;
  localparam int NBITS = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             step;
  logic             count_up;
  logic [NBITS-1:0] pos;
  logic             err;

  always #5 clk = ~clk;

  quad_decoder #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_in     (a_in),
    .b_in     (b_in),
    .clr      (clr),
    .step     (step),
    .count_up (count_up),
    .pos      (pos),
    .err      (err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic             cu;
    logic [NBITS-1:0] pos;
    logic             err;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && step === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: actual step=1 at cycle %0d required step=0", cyc);
      end else begin
        e = sb.pop_front();
        check("step_cycle", cyc, e.cyc);
        check("step_dir", count_up, e.cu);
        check("step_pos", pos, e.pos);
        check("step_err", err, e.err);
      end
    end
  end

  // Called just after a rising edge; the pulse is expected three edges later.
  task automatic drv(input logic [1:0] ab, input int hold, input bit exp_step,
                     input logic cu, input logic [NBITS-1:0] p, input logic e);
    exp_t x;
    {a_in, b_in} = ab;
    if (exp_step) begin
      x.cu  = cu;
      x.pos = p;
      x.err = e;
      x.cyc = cyc + 3;
      sb.push_back(x);
    end
    repeat (hold) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_in  = 1'b1;
    b_in  = 1'b1;
    clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", step, 0);
    check("rst_count_up", count_up, 1);
    check("rst_pos", pos, 0);
    check("rst_err", err, 0);

    // Inputs at 11 through reset release: no spurious activity.
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("hold11_err", err, 0);
    check("hold11_pos", pos, 0);

    reset = 1'b1;
    {a_in, b_in} = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    drv(2'b01, 4, 1, 1'b1, 4'd1, 1'b0);
    drv(2'b11, 4, 1, 1'b1, 4'd2, 1'b0);
    drv(2'b10, 4, 1, 1'b1, 4'd3, 1'b0);
    drv(2'b00, 4, 1, 1'b1, 4'd4, 1'b0);
    check("fwd_pos", pos, 4);
    check("fwd_dir", count_up, 1);

    drv(2'b10, 4, 1, 1'b0, 4'd3, 1'b0);
    drv(2'b11, 4, 1, 1'b0, 4'd2, 1'b0);
    drv(2'b01, 4, 1, 1'b0, 4'd1, 1'b0);
    drv(2'b00, 4, 1, 1'b0, 4'd0, 1'b0);
    drv(2'b10, 4, 1, 1'b0, 4'd15, 1'b0);
    drv(2'b11, 4, 1, 1'b0, 4'd14, 1'b0);
    check("bwd_wrap_pos", pos, 14);
    check("bwd_dir", count_up, 0);

    drv(2'b10, 4, 1, 1'b1, 4'd15, 1'b0);
    drv(2'b00, 4, 1, 1'b1, 4'd0, 1'b0);
    drv(2'b11, 4, 0, 1'b0, 4'd0, 1'b0);
    check("illegal_err", err, 1);
    check("illegal_pos", pos, 0);
    check("illegal_dir", count_up, 1);
    drv(2'b10, 4, 1, 1'b1, 4'd1, 1'b1);
    check("sticky_err", err, 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_pos", pos, 0);
    check("clr_err", err, 0);

    drv(2'b00, 4, 1, 1'b1, 4'd1, 1'b0);
    drv(2'b01, 4, 1, 1'b1, 4'd2, 1'b0);
    drv(2'b11, 4, 1, 1'b1, 4'd3, 1'b0);
    drv(2'b10, 4, 1, 1'b1, 4'd4, 1'b0);
    drv(2'b00, 4, 1, 1'b1, 4'd5, 1'b0);
    drv(2'b01, 4, 1, 1'b1, 4'd6, 1'b0);
    drv(2'b11, 4, 1, 1'b1, 4'd7, 1'b0);
    check("pre_clr_pos", pos, 7);
    // Clear lands on the same edge the 11->10 step is evaluated.
    drv(2'b10, 2, 1, 1'b1, 4'd0, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("clr_step_pos", pos, 0);
    check("clr_step_dir", count_up, 1);

    drv(2'b00, 4, 1, 1'b1, 4'd1, 1'b0);
    drv(2'b01, 4, 1, 1'b1, 4'd2, 1'b0);
    drv(2'b11, 4, 1, 1'b1, 4'd3, 1'b0);
    drv(2'b10, 4, 1, 1'b1, 4'd4, 1'b0);
    drv(2'b00, 4, 1, 1'b1, 4'd5, 1'b0);
    drv(2'b01, 4, 1, 1'b1, 4'd6, 1'b0);
    drv(2'b11, 4, 1, 1'b1, 4'd7, 1'b0);
    drv(2'b10, 4, 1, 1'b1, 4'd8, 1'b0);
    drv(2'b00, 4, 1, 1'b1, 4'd9, 1'b0);
    check("pre_rst_pos", pos, 9);

    {a_in, b_in} = 2'b01;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_step", step, 0);
    check("async_rst_pos", pos, 0);
    check("async_rst_err", err, 0);
    check("async_rst_dir", count_up, 1);
    #2;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_pos", pos, 0);
    check("post_rst_err", err, 0);

    check("missed_steps", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
